// File: rtl/scb_pkg.sv
// Shared definitions for the stream scoreboard: FSM states and FP32 field layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package scb_pkg;

  // Scoreboard run phases.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } scb_state_e;

  // IEEE-754 single-precision field positions.
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_MAN_MSB  = 22;
  localparam int FP32_MAN_LSB  = 0;

  // Drain counter is wide enough for the largest legal LATENCY (64).
  localparam int DRAIN_CNT_W = 7;

endpackage

// File: rtl/scb_delay_line.sv
// Fixed-depth shift register of {valid, payload} entries; MSB of the entry is the valid bit.
// Latency: LATENCY cycles from entry_i to entry_o.
// Backpressure: none; shifts every cycle unconditionally.
module scb_delay_line #(
  parameter int WIDTH   = 33,
  parameter int LATENCY = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] entry_i,
  output logic [WIDTH-1:0] entry_o
);

  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-2:0]   dat_q [LATENCY];

  // Valid bits are reset so nothing stale is ever checked after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= entry_i[WIDTH-1];
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Payload is qualified by the valid bit, so it needs no reset.
  always_ff @(posedge clk_i) begin
    dat_q[0] <= entry_i[WIDTH-2:0];
    for (int i = 1; i < LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign entry_o = {vld_q[LATENCY-1], dat_q[LATENCY-1]};

endmodule

// File: rtl/stream_scoreboard.sv
// Checks a DUT output stream against golden values delayed by the DUT pipeline depth.
// Latency: word checked LATENCY cycles after DATA_EN; MISMATCH/counters update one cycle later.
// Backpressure: none; optional macro SCB_ULP_TOL_EN enables FP32 mantissa tolerance.
module stream_scoreboard
  import scb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16,
  parameter int ULP_TOL = 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             DATA_EN,
  input  logic [WIDTH-1:0] EXP_IN,
  input  logic             END_SIM,
  input  logic [WIDTH-1:0] DIN,
  output logic             MISMATCH,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             DONE,
  output logic             PASS
);

  localparam logic [CNT_W-1:0]       CNT_MAX    = '1;
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(LATENCY - 1);

  scb_state_e             state_q;
  logic [DRAIN_CNT_W-1:0] drain_q;
  logic                   done_q;
  logic                   pass_q;
  logic                   mismatch_q;
  logic [CNT_W-1:0]       chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;

  logic                   entry_vld;
  logic [WIDTH:0]         entry_in;
  logic [WIDTH:0]         entry_out;
  logic                   chk_vld;
  logic [WIDTH-1:0]       chk_exp;
  logic                   word_ok;
  logic                   word_bad;

  // New stimulus is only accepted before the drain phase begins; the word that
  // arrives together with END_SIM is still taken.
  assign entry_vld = DATA_EN && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign entry_in  = {entry_vld, EXP_IN};

  scb_delay_line #(
    .WIDTH   (WIDTH + 1),
    .LATENCY (LATENCY)
  ) u_delay_line (
    .clk_i   (CLK),
    .rst_ni  (RST_n),
    .entry_i (entry_in),
    .entry_o (entry_out)
  );

  assign chk_vld = entry_out[WIDTH] && (state_q != ST_FINISH);
  assign chk_exp = entry_out[WIDTH-1:0];

`ifdef SCB_ULP_TOL_EN
  localparam logic [31:0] ULP_TOL_V = 32'(ULP_TOL);
  logic [31:0] man_got, man_exp, man_diff;

  // Sign and exponent must agree exactly; mantissas may differ by up to ULP_TOL.
  always_comb begin
    man_got  = 32'(DIN[FP32_MAN_MSB:FP32_MAN_LSB]);
    man_exp  = 32'(chk_exp[FP32_MAN_MSB:FP32_MAN_LSB]);
    man_diff = (man_got >= man_exp) ? (man_got - man_exp) : (man_exp - man_got);
    word_ok  = (DIN[FP32_SIGN_BIT] == chk_exp[FP32_SIGN_BIT]) &&
               (DIN[FP32_EXP_MSB:FP32_EXP_LSB] == chk_exp[FP32_EXP_MSB:FP32_EXP_LSB]) &&
               (man_diff <= ULP_TOL_V);
  end
`else
  // Exact bit-for-bit equality.
  assign word_ok = (DIN == chk_exp);
`endif

  assign word_bad = chk_vld && !word_ok;

  // Saturating next-state for the check and error counters.
  always_comb begin
    chk_cnt_d = chk_cnt_q;
    err_cnt_d = err_cnt_q;
    if (chk_vld) begin
      if (chk_cnt_q != CNT_MAX) chk_cnt_d = chk_cnt_q + CNT_W'(1);
      if (!word_ok && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Counter and mismatch-pulse registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      chk_cnt_q  <= chk_cnt_d;
      err_cnt_q  <= err_cnt_d;
      mismatch_q <= word_bad;
    end
  end

  // Run-phase FSM with registered DONE/PASS; PASS uses the error count that
  // includes any check landing on the final drain cycle.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (END_SIM)      state_q <= ST_DRAIN;
          else if (DATA_EN) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (END_SIM) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end else begin
            drain_q <= drain_q + DRAIN_CNT_W'(1);
          end
        end
        ST_FINISH: begin
          state_q <= ST_FINISH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MISMATCH = mismatch_q;
  assign CHK_CNT  = chk_cnt_q;
  assign ERR_CNT  = err_cnt_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;

endmodule
